// File: rtl/gf16_pkg.sv
// GF(2^4) arithmetic shared by the masked S-box datapath.
// Polynomial basis, reduction polynomial x^4+x+1.
package gf16_pkg;

  typedef logic [3:0] gf16_t;

  localparam logic [4:0] GF16_POLY = 5'b10011;

  function automatic gf16_t gf16_mul(input gf16_t a, input gf16_t b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ (7'(a) << i);
    end
    for (int i = 6; i >= 4; i--) begin
      if (p[i]) p = p ^ (7'(GF16_POLY) << (i - 4));
    end
    return p[3:0];
  endfunction

  // Squaring is linear over GF(2): x^4 = x+1, x^6 = x^3+x^2.
  function automatic gf16_t gf16_sq(input gf16_t a);
    return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
  endfunction

  function automatic gf16_t gf16_scale(input gf16_t a, input gf16_t nu);
    return gf16_mul(a, nu);
  endfunction

  // Row-major index of share pair (i,j), i<j.
  function automatic int rnd_idx(input int i, input int j, input int shares);
    return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/gf16_mul_sqsc_dom_if.sv
// Operand/result bundle of the masked GF(16) multiply-square-scale unit.
interface gf16_mul_sqsc_dom_if #(
  parameter int SHARES = 2
);
  localparam int NPAIR = SHARES * (SHARES - 1) / 2;

  logic                    in_valid;
  logic [4*SHARES-1:0]     a_sh;
  logic [4*SHARES-1:0]     b_sh;
  logic [4*NPAIR-1:0]      rnd;
  logic                    out_valid;
  logic [4*SHARES-1:0]     q_sh;

  modport master (
    output in_valid, a_sh, b_sh, rnd,
    input  out_valid, q_sh
  );

  modport slave (
    input  in_valid, a_sh, b_sh, rnd,
    output out_valid, q_sh
  );

endinterface

// File: rtl/gf16_dom_cell.sv
// One registered DOM product term R[i][j]; the inner cell also adds the
// per-share square-scale term, cross cells are blinded by their random word.
module gf16_dom_cell
  import gf16_pkg::*;
#(
  parameter bit    INNER = 1'b0,
  parameter gf16_t NU    = 4'hC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  gf16_t a_i,
  input  gf16_t b_j,
  input  gf16_t r_k,
  output gf16_t r_o
);

  gf16_t r_d;
  gf16_t r_q;

  always_comb begin
    r_d = r_q;
    if (en) begin
      if (INNER) begin
        r_d = gf16_mul(a_i, b_j) ^ gf16_scale(gf16_sq(a_i ^ b_j), NU) ^ r_k;
      end else begin
        r_d = gf16_mul(a_i, b_j) ^ r_k;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/gf16_mul_sqsc_dom.sv
// Masked Q = A*B ^ NU*(A^B)^2 over GF(16), DOM-indep with SHARES shares.
// Define GF16_MSQ_OUTREG_EN to register the compressed output (latency 2).
module gf16_mul_sqsc_dom
  import gf16_pkg::*;
#(
  parameter int    SHARES = 2,
  parameter gf16_t NU     = 4'hC
) (
  input  logic                      clk,
  input  logic                      rst,
  gf16_mul_sqsc_dom_if.slave        bus
);

  gf16_t               dom_r [SHARES][SHARES];
  logic [4*SHARES-1:0] q_comb;
  logic                v1_d;
  logic                v1_q;

  for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
      localparam int LO = (gi < gj) ? gi : gj;
      localparam int HI = (gi < gj) ? gj : gi;
      gf16_t r_word;

      // Inner domain takes no randomness; cross pairs (i,j) and (j,i) share word k.
      if (gi == gj) begin : g_inner
        assign r_word = '0;
      end else begin : g_cross
        assign r_word = bus.rnd[4*rnd_idx(LO, HI, SHARES) +: 4];
      end

      gf16_dom_cell #(
        .INNER (gi == gj),
        .NU    (NU)
      ) u_cell (
        .clk (clk),
        .rst (rst),
        .en  (bus.in_valid),
        .a_i (bus.a_sh[4*gi +: 4]),
        .b_j (bus.b_sh[4*gj +: 4]),
        .r_k (r_word),
        .r_o (dom_r[gi][gj])
      );
    end
  end

  // Compression reads registered terms only.
  always_comb begin
    q_comb = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        q_comb[4*i +: 4] = q_comb[4*i +: 4] ^ dom_r[i][j];
      end
    end
  end

  assign v1_d = bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
    end
  end

`ifdef GF16_MSQ_OUTREG_EN
  logic [4*SHARES-1:0] q_out_d;
  logic [4*SHARES-1:0] q_out_q;
  logic                v2_d;
  logic                v2_q;

  always_comb begin
    q_out_d = q_out_q;
    if (v1_q) q_out_d = q_comb;
    v2_d = v1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_out_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      q_out_q <= q_out_d;
      v2_q    <= v2_d;
    end
  end

  assign bus.q_sh      = q_out_q;
  assign bus.out_valid = v2_q;
`else
  assign bus.q_sh      = q_comb;
  assign bus.out_valid = v1_q;
`endif

endmodule
